// File: rtl/debug_gpio_mux.sv
// debug_gpio_mux: routes each of N_GPIO debug pins to a selectable internal status, index-match or PWM signal.
// Latency: 2 cycles from input change to pin (input register stage, then pin register stage).
// Backpressure: none; free-running outputs, config double-buffered and applied only on a pending UPDATE.
module debug_gpio_mux #(
    parameter int DEPTH     = 249,
    parameter int N_GPIO    = 4,
    parameter int STRETCH_W = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [8:0]              TIME_CNT,
    input  logic                    UPDATE,
    input  logic                    SYNC,
    input  logic                    THERMO,
    input  logic                    FORCE_FAN,
    input  logic [15:0]             STM_IDX,
    input  logic                    STM_SEGMENT,
    input  logic [14:0]             MOD_IDX,
    input  logic                    MOD_SEGMENT,
    input  logic [DEPTH-1:0]        PWM_OUT,
    input  logic                    CFG_VALID,
    input  logic [N_GPIO-1:0][7:0]  CFG_TYPE,
    input  logic [N_GPIO-1:0][15:0] CFG_VALUE,
    output logic [N_GPIO-1:0]       GPIO_OUT
);

    localparam logic [7:0] SRC_NONE      = 8'h00;
    localparam logic [7:0] SRC_BASE      = 8'h01;
    localparam logic [7:0] SRC_THERMO    = 8'h02;
    localparam logic [7:0] SRC_FORCE_FAN = 8'h03;
    localparam logic [7:0] SRC_SYNC_STR  = 8'h04;
    localparam logic [7:0] SRC_MOD_SEG   = 8'h05;
    localparam logic [7:0] SRC_MOD_MATCH = 8'h06;
    localparam logic [7:0] SRC_STM_SEG   = 8'h07;
    localparam logic [7:0] SRC_STM_MATCH = 8'h08;
    localparam logic [7:0] SRC_PWM       = 8'h09;
    localparam logic [7:0] SRC_DIRECT    = 8'hE0;

    // PWM selects use an 8-bit index; anything at or beyond DEPTH reads as 0.
    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

    // Configuration: shadow captured on CFG_VALID, active loaded from shadow on a pending UPDATE.
    logic [N_GPIO-1:0][7:0]  shadow_type_q, shadow_type_d;
    logic [N_GPIO-1:0][15:0] shadow_value_q, shadow_value_d;
    logic [N_GPIO-1:0][7:0]  active_type_q, active_type_d;
    logic [N_GPIO-1:0][15:0] active_value_q, active_value_d;
    logic                    pending_q, pending_d;
    logic                    apply;

    // Stage 1: registered copies of every tapped input.
    logic [8:0]       time_cnt_q;
    logic             thermo_q;
    logic             force_fan_q;
    logic             sync_q;
    logic             sync_prev_q;
    logic [15:0]      stm_idx_q;
    logic             stm_seg_q;
    logic [14:0]      mod_idx_q;
    logic             mod_seg_q;
    logic [DEPTH-1:0] pwm_q;
    logic [255:0]     pwm_pad;
    logic             sync_edge;

    // Per-pin pulse-stretch counters and the pin register (stage 2).
    logic [N_GPIO-1:0][STRETCH_W-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [N_GPIO-1:0]                gpio_q, gpio_d;

    // A zero VALUE still produces a one-cycle pulse.
    function automatic logic [STRETCH_W-1:0] stretch_len(input logic [15:0] v);
        logic [STRETCH_W-1:0] t;
        t = STRETCH_W'(v);
        return (t == '0) ? STRETCH_W'(1) : t;
    endfunction

    assign apply     = UPDATE && pending_q;
    assign sync_edge = sync_q && !sync_prev_q;

    // Zero-extend the PWM tap to the full 8-bit index space.
    always_comb begin
        pwm_pad              = '0;
        pwm_pad[DEPTH-1:0]   = pwm_q;
    end

    // Next-state for the double-buffered configuration; a coincident CFG_VALID always lands in shadow.
    always_comb begin
        shadow_type_d  = shadow_type_q;
        shadow_value_d = shadow_value_q;
        active_type_d  = active_type_q;
        active_value_d = active_value_q;
        pending_d      = pending_q;
        if (apply) begin
            active_type_d  = shadow_type_q;
            active_value_d = shadow_value_q;
            pending_d      = 1'b0;
        end
        if (CFG_VALID) begin
            shadow_type_d  = CFG_TYPE;
            shadow_value_d = CFG_VALUE;
            pending_d      = 1'b1;
        end
    end

    // Stretch counters: cleared on config apply, (re)loaded on a SYNC rising edge, else count down to 0.
    always_comb begin
        stretch_cnt_d = stretch_cnt_q;
        for (int p = 0; p < N_GPIO; p++) begin
            if (apply) begin
                stretch_cnt_d[p] = '0;
            end else if (sync_edge) begin
                stretch_cnt_d[p] = stretch_len(active_value_q[p]);
            end else if (stretch_cnt_q[p] != '0) begin
                stretch_cnt_d[p] = stretch_cnt_q[p] - STRETCH_W'(1);
            end
        end
    end

    // Per-pin source select from the stage-1 registers.
    always_comb begin
        gpio_d = '0;
        for (int p = 0; p < N_GPIO; p++) begin
            case (active_type_q[p])
                SRC_NONE:      gpio_d[p] = 1'b0;
                SRC_BASE:      gpio_d[p] = (time_cnt_q < 9'd256);
                SRC_THERMO:    gpio_d[p] = thermo_q;
                SRC_FORCE_FAN: gpio_d[p] = force_fan_q;
                SRC_SYNC_STR:  gpio_d[p] = (stretch_cnt_d[p] != '0);
                SRC_MOD_SEG:   gpio_d[p] = mod_seg_q;
                SRC_MOD_MATCH: gpio_d[p] = (mod_idx_q == active_value_q[p][14:0]);
                SRC_STM_SEG:   gpio_d[p] = stm_seg_q;
                SRC_STM_MATCH: gpio_d[p] = (stm_idx_q == active_value_q[p]);
                SRC_PWM:       gpio_d[p] = ({1'b0, active_value_q[p][7:0]} < DEPTH_LIM)
                                           ? pwm_pad[active_value_q[p][7:0]] : 1'b0;
                SRC_DIRECT:    gpio_d[p] = active_value_q[p][0];
                default:       gpio_d[p] = 1'b0;
            endcase
        end
    end

    // Configuration and stretch state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_type_q  <= '0;
            shadow_value_q <= '0;
            active_type_q  <= '0;
            active_value_q <= '0;
            pending_q      <= 1'b0;
            stretch_cnt_q  <= '0;
        end else begin
            shadow_type_q  <= shadow_type_d;
            shadow_value_q <= shadow_value_d;
            active_type_q  <= active_type_d;
            active_value_q <= active_value_d;
            pending_q      <= pending_d;
            stretch_cnt_q  <= stretch_cnt_d;
        end
    end

    // Stage 1 input capture, including the SYNC edge-detect history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            time_cnt_q  <= '0;
            thermo_q    <= 1'b0;
            force_fan_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            stm_idx_q   <= '0;
            stm_seg_q   <= 1'b0;
            mod_idx_q   <= '0;
            mod_seg_q   <= 1'b0;
            pwm_q       <= '0;
        end else begin
            time_cnt_q  <= TIME_CNT;
            thermo_q    <= THERMO;
            force_fan_q <= FORCE_FAN;
            sync_q      <= SYNC;
            sync_prev_q <= sync_q;
            stm_idx_q   <= STM_IDX;
            stm_seg_q   <= STM_SEGMENT;
            mod_idx_q   <= MOD_IDX;
            mod_seg_q   <= MOD_SEGMENT;
            pwm_q       <= PWM_OUT;
        end
    end

    // Stage 2 pin register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign GPIO_OUT = gpio_q;

endmodule

// File: tb/tb_debug_gpio_mux.sv
// Testbench for debug_gpio_mux: directed test-plan steps followed by a randomized run,
// each pin compared every cycle against a cycle-indexed behavioural model.
module tb_debug_gpio_mux;

    localparam int DEPTH     = 249;
    localparam int N_GPIO    = 4;
    localparam int STRETCH_W = 16;

    logic                    CLK = 1'b0;
    logic                    RST = 1'b1;
    logic [8:0]              TIME_CNT = '0;
    logic                    UPDATE = 1'b0;
    logic                    SYNC = 1'b0;
    logic                    THERMO = 1'b0;
    logic                    FORCE_FAN = 1'b0;
    logic [15:0]             STM_IDX = '0;
    logic                    STM_SEGMENT = 1'b0;
    logic [14:0]             MOD_IDX = '0;
    logic                    MOD_SEGMENT = 1'b0;
    logic [DEPTH-1:0]        PWM_OUT = '0;
    logic                    CFG_VALID = 1'b0;
    logic [N_GPIO-1:0][7:0]  CFG_TYPE = '0;
    logic [N_GPIO-1:0][15:0] CFG_VALUE = '0;
    logic [N_GPIO-1:0]       GPIO_OUT;

    debug_gpio_mux #(
        .DEPTH     (DEPTH),
        .N_GPIO    (N_GPIO),
        .STRETCH_W (STRETCH_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TIME_CNT    (TIME_CNT),
        .UPDATE      (UPDATE),
        .SYNC        (SYNC),
        .THERMO      (THERMO),
        .FORCE_FAN   (FORCE_FAN),
        .STM_IDX     (STM_IDX),
        .STM_SEGMENT (STM_SEGMENT),
        .MOD_IDX     (MOD_IDX),
        .MOD_SEGMENT (MOD_SEGMENT),
        .PWM_OUT     (PWM_OUT),
        .CFG_VALID   (CFG_VALID),
        .CFG_TYPE    (CFG_TYPE),
        .CFG_VALUE   (CFG_VALUE),
        .GPIO_OUT    (GPIO_OUT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: configuration registers as described by the config rules.
    logic [7:0]  m_sh_type  [N_GPIO];
    logic [15:0] m_sh_val   [N_GPIO];
    logic [7:0]  m_act_type [N_GPIO];
    logic [15:0] m_act_val  [N_GPIO];
    bit          m_pending;
    // Last cycle number during which a stretched pulse is still high (-1: none).
    int          m_dead     [N_GPIO];
    // Inputs of the previous cycle (what the pins reflect two cycles later).
    logic [8:0]       p_time;
    bit               p_thermo, p_fan, p_stm_seg, p_mod_seg;
    logic [15:0]      p_stm_idx;
    logic [14:0]      p_mod_idx;
    logic [DEPTH-1:0] p_pwm;
    bit               s1, s2;   // SYNC one and two cycles back

    task automatic model_reset();
        for (int p = 0; p < N_GPIO; p++) begin
            m_sh_type[p] = '0; m_sh_val[p] = '0;
            m_act_type[p] = '0; m_act_val[p] = '0;
            m_dead[p] = -1;
        end
        m_pending = 0;
        p_time = '0; p_thermo = 0; p_fan = 0; p_stm_seg = 0; p_mod_seg = 0;
        p_stm_idx = '0; p_mod_idx = '0; p_pwm = '0;
        s1 = 0; s2 = 0;
    endtask

    function automatic bit ref_level(input logic [7:0] t, input logic [15:0] v, input bit str_hi);
        int idx;
        idx = int'(v[7:0]);
        case (t)
            8'h01: return (int'(p_time) < 256);
            8'h02: return p_thermo;
            8'h03: return p_fan;
            8'h04: return str_hi;
            8'h05: return p_mod_seg;
            8'h06: return (p_mod_idx == v[14:0]);
            8'h07: return p_stm_seg;
            8'h08: return (p_stm_idx == v);
            8'h09: begin
                if (idx < DEPTH) return p_pwm[idx];
                return 0;
            end
            8'hE0: return v[0];
            default: return 0;
        endcase
    endfunction

    // One clock cycle: model consumes the inputs sampled at this edge, then the pins are compared.
    task automatic tick();
        logic [N_GPIO-1:0] exp_gpio;
        bit apply, sedge;
        int len;
        exp_gpio = '0;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            apply = UPDATE && m_pending;
            sedge = s1 && !s2;
            for (int p = 0; p < N_GPIO; p++) begin
                len = (m_act_val[p] == 16'd0) ? 1 : int'(m_act_val[p]);
                if (apply) m_dead[p] = -1;
                else if (sedge) m_dead[p] = cyc + len;
                exp_gpio[p] = ref_level(m_act_type[p], m_act_val[p], (cyc + 1) <= m_dead[p]);
            end
            if (apply) begin
                for (int p = 0; p < N_GPIO; p++) begin
                    m_act_type[p] = m_sh_type[p];
                    m_act_val[p]  = m_sh_val[p];
                end
                m_pending = 0;
            end
            if (CFG_VALID) begin
                for (int p = 0; p < N_GPIO; p++) begin
                    m_sh_type[p] = CFG_TYPE[p];
                    m_sh_val[p]  = CFG_VALUE[p];
                end
                m_pending = 1;
            end
            p_time = TIME_CNT; p_thermo = THERMO; p_fan = FORCE_FAN;
            p_stm_seg = STM_SEGMENT; p_mod_seg = MOD_SEGMENT;
            p_stm_idx = STM_IDX; p_mod_idx = MOD_IDX; p_pwm = PWM_OUT;
            s2 = s1; s1 = SYNC;
        end
        cyc++;
        @(negedge CLK);
        checks++;
        assert (GPIO_OUT === exp_gpio) else begin
            failures++;
            $error("FAIL gpio cyc=%0d got=%b exp=%b", cyc, GPIO_OUT, exp_gpio);
        end
    endtask

    task automatic rand_inputs(input bit narrow);
        TIME_CNT    = 9'($urandom_range(0, 511));
        SYNC        = 1'($urandom_range(0, 1));
        THERMO      = 1'($urandom_range(0, 1));
        FORCE_FAN   = 1'($urandom_range(0, 1));
        STM_SEGMENT = 1'($urandom_range(0, 1));
        MOD_SEGMENT = 1'($urandom_range(0, 1));
        STM_IDX     = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
        MOD_IDX     = narrow ? 15'($urandom_range(0, 3)) : 15'($urandom);
        for (int i = 0; i < DEPTH; i++) PWM_OUT[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic cfg_pulse();
        CFG_VALID = 1'b1; tick(); CFG_VALID = 1'b0;
    endtask

    task automatic update_pulse();
        UPDATE = 1'b1; tick(); UPDATE = 1'b0;
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] rand_type();
        int k;
        k = int'($urandom_range(0, 11));
        if (k <= 9) return 8'(k);
        if (k == 10) return 8'hE0;
        return 8'($urandom);
    endfunction

    initial begin
        int cnt;
        logic [7:0] t;
        model_reset();

        // Reset state.
        RST = 1'b1;
        repeat (3) tick();
        check_val("reset_gpio", int'(GPIO_OUT), 0);
        RST = 1'b0;

        // No configuration: toggling every input (and UPDATE) leaves pins low.
        repeat (40) begin
            rand_inputs(1'b0);
            UPDATE = 1'($urandom_range(0, 1));
            tick();
        end
        UPDATE = 1'b0;
        check_val("noconfig_gpio", int'(GPIO_OUT), 0);

        // pin0 BASE, pin1 PWM[5]; nothing changes before UPDATE.
        CFG_TYPE[0] = 8'h01; CFG_VALUE[0] = 16'd0;
        CFG_TYPE[1] = 8'h09; CFG_VALUE[1] = 16'd5;
        cfg_pulse();
        repeat (10) begin rand_inputs(1'b0); tick(); end
        check_val("pre_update_gpio", int'(GPIO_OUT), 0);
        update_pulse();
        for (int k = 0; k < 520; k++) begin
            TIME_CNT = 9'(k % 512);
            for (int i = 0; i < DEPTH; i++) PWM_OUT[i] = 1'($urandom_range(0, 1));
            tick();
        end

        // pin2 SYNC stretch of 10, then retrigger, then VALUE 0.
        CFG_TYPE[2] = 8'h04; CFG_VALUE[2] = 16'd10;
        SYNC = 1'b0;
        cfg_pulse();
        update_pulse();
        repeat (3) tick();
        SYNC = 1'b1; tick(); SYNC = 1'b0;
        cnt = 0;
        repeat (20) begin tick(); cnt += int'(GPIO_OUT[2]); end
        check_val("stretch10_len", cnt, 10);

        cnt = 0;
        SYNC = 1'b1; tick(); cnt += int'(GPIO_OUT[2]); SYNC = 1'b0;
        repeat (4) begin tick(); cnt += int'(GPIO_OUT[2]); end
        SYNC = 1'b1; tick(); cnt += int'(GPIO_OUT[2]); SYNC = 1'b0;
        repeat (20) begin tick(); cnt += int'(GPIO_OUT[2]); end
        check_val("retrigger_len", cnt, 15);

        CFG_VALUE[2] = 16'd0;
        cfg_pulse();
        update_pulse();
        repeat (3) tick();
        cnt = 0;
        SYNC = 1'b1; tick(); SYNC = 1'b0;
        repeat (10) begin tick(); cnt += int'(GPIO_OUT[2]); end
        check_val("stretch0_len", cnt, 1);

        // pin3 STM index match, pin0 PWM with out-of-range index.
        CFG_TYPE[3] = 8'h08; CFG_VALUE[3] = 16'h0123;
        CFG_TYPE[0] = 8'h09; CFG_VALUE[0] = 16'd249;
        STM_IDX = 16'h0000;
        cfg_pulse();
        update_pulse();
        repeat (3) tick();
        cnt = 0;
        for (int v = 16'h0120; v <= 16'h0126; v++) begin
            STM_IDX = 16'(v);
            PWM_OUT = '1;
            tick();
            cnt += int'(GPIO_OUT[3]);
        end
        STM_IDX = 16'h0000;
        repeat (3) begin tick(); cnt += int'(GPIO_OUT[3]); end
        check_val("stm_match_count", cnt, 1);
        check_val("pwm_oob_pin0", int'(GPIO_OUT[0]), 0);

        // CFG_VALID coincident with UPDATE (nothing pending): old config persists.
        for (int p = 0; p < N_GPIO; p++) begin CFG_TYPE[p] = 8'hE0; CFG_VALUE[p] = 16'd1; end
        CFG_VALID = 1'b1; UPDATE = 1'b1;
        tick();
        CFG_VALID = 1'b0; UPDATE = 1'b0;
        repeat (5) tick();
        check_val("coincident_old_pin0", int'(GPIO_OUT[0]), 0);
        update_pulse();
        tick();
        check_val("coincident_new_all", int'(GPIO_OUT), 15);

        // Reset during an active stretch with a pending config.
        for (int p = 0; p < N_GPIO; p++) begin CFG_TYPE[p] = 8'hE0; CFG_VALUE[p] = 16'd1; end
        CFG_TYPE[2] = 8'h04; CFG_VALUE[2] = 16'd1000;
        cfg_pulse();
        update_pulse();
        SYNC = 1'b1; tick(); SYNC = 1'b0;
        repeat (4) tick();
        check_val("mid_stretch_pin2", int'(GPIO_OUT[2]), 1);
        CFG_TYPE[2] = 8'hE0; CFG_VALUE[2] = 16'd1;
        cfg_pulse();
        RST = 1'b1; tick(); RST = 1'b0;
        check_val("rst_clears_gpio", int'(GPIO_OUT), 0);
        update_pulse();
        repeat (20) begin rand_inputs(1'b0); tick(); end
        check_val("post_rst_none", int'(GPIO_OUT), 0);

        // Randomized run: random configs, updates, occasional reset.
        for (int k = 0; k < 2500; k++) begin
            rand_inputs(1'b1);
            if ($urandom_range(0, 7) == 0) begin
                for (int p = 0; p < N_GPIO; p++) begin
                    t = rand_type();
                    CFG_TYPE[p] = t;
                    case (t)
                        8'h04:        CFG_VALUE[p] = 16'($urandom_range(0, 20));
                        8'h06, 8'h08: CFG_VALUE[p] = 16'($urandom_range(0, 3));
                        8'h09:        CFG_VALUE[p] = 16'($urandom_range(0, 255));
                        default:      CFG_VALUE[p] = 16'($urandom);
                    endcase
                end
                CFG_VALID = 1'b1;
            end else begin
                CFG_VALID = 1'b0;
            end
            UPDATE = ($urandom_range(0, 5) == 0);
            RST    = ($urandom_range(0, 299) == 0);
            tick();
        end
        CFG_VALID = 1'b0; UPDATE = 1'b0; RST = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
